axi_llc_tag_sram_sched: RTL and testbench
=========================================

// Module: axi_llc_tag_sram_sched
// PURPOSE
//  Owns the tag SRAM port of one LLC slice; sequences power-up init/BIST, then arbitrates.
//  After reset it starts the tag pattern generator and passes its SRAM traffic through to all ways.
//  After the generator's EOC it arbitrates lookup (lu) and flush (fl) requesters round-robin.
//  Read completions are routed back to the issuing requester after a fixed SRAM latency.
// PARAMETERS
//  SetAssociativity  8   number of ways; width of way masks
//  IndexLength       8   set index width
//  PatternWidth      20  tag entry width {val, dit, tag}
//  RdLatency         1   SRAM read latency in cycles; must be >= 1
// PORTS
//  clk_i          in   1                 clock, rising edge
//  rst_ni         in   1                 asynchronous reset, active low
//  init_done_o    out  1                 BIST finished; arbitration open
//  gen_valid_o    out  1                 start request to pattern generator
//  gen_ready_i    in   1                 generator idle/ready
//  gen_req_i      in   1                 generator SRAM request
//  gen_we_i       in   1                 generator write enable
//  gen_index_i    in   IndexLength       generator index
//  gen_pattern_i  in   PatternWidth      generator write pattern
//  gen_eoc_i      in   1                 generator end of computation (level)
//  lu_valid_i / lu_ready_o       in/out  1   lookup request handshake
//  lu_we_i, lu_way_i, lu_index_i, lu_wdata_i  in  1/SetAssociativity/IndexLength/PatternWidth
//  lu_rvalid_o    out  1                 lookup read data valid on SRAM rdata this cycle
//  fl_valid_i / fl_ready_o       in/out  1   flush request handshake
//  fl_we_i, fl_way_i, fl_index_i, fl_wdata_i  in  same widths as lu_*
//  fl_rvalid_o    out  1                 flush read data valid
//  sram_req_o, sram_we_o  out  1         SRAM strobe, write enable
//  sram_way_o     out  SetAssociativity  per-way enable
//  sram_index_o   out  IndexLength       SRAM address
//  sram_wdata_o   out  PatternWidth      SRAM write data
//  stall_cnt_o    out  32                stall statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state INIT_START; all outputs 0; RR pointer = lu; rvalid pipeline cleared.
//  FSM: INIT_START -> gen_valid_o=1 until gen_ready_i=1 (handshake) -> INIT_RUN.
//   INIT_RUN: SRAM driven from gen_*, sram_way_o='1; lu/fl_ready_o=0.
//   INIT_RUN -> OPERATE on first cycle gen_eoc_i=1; init_done_o=1 from next cycle, sticky.
//  OPERATE: one grant per cycle, combinational; transfer = valid&ready in same cycle as sram_req_o.
//   Only one valid -> granted. Both valid -> requester at RR pointer wins.
//   After a both-valid grant, RR pointer moves to the loser (fairness: alternating grants).
//   No grant -> sram_req_o=0; sram_we/way/index/wdata=0.
//  Requester holds valid and payload stable until ready; valid is never withdrawn.
//  Response routing: granted read (we=0) pushes requester id into a RdLatency-deep shift register.
//   x_rvalid_o is asserted exactly RdLatency cycles after the grant, for 1 cycle.
//   Writes produce no rvalid. Back-to-back reads pipeline; no response backpressure.
//  gen_* ignored outside INIT_RUN; lu/fl ignored before OPERATE.
//  Reset mid-BIST or mid-read: pipeline flushed, sequence restarts at INIT_START.
// CONFIGURATION
//  AXI_LLC_TAG_SCHED_STATS_EN defined:
//   stall_cnt_o counts cycles in OPERATE with a requester valid and not ready.
//   Saturates at 32'hFFFF_FFFF; cleared only by reset.
//  Macro undefined: counter not instantiated; stall_cnt_o tied to '0.
// TESTING
//  Reset release, gen_ready_i=1 -> gen_valid_o high 1 cycle; sram_way_o=8'hFF during gen_req_i.
//  gen_eoc_i=1 at cycle N -> init_done_o=1 at N+1; lu_valid_i before N+1 -> lu_ready_o=0.
//  lu and fl read valid together 4 cycles -> grants lu,fl,lu,fl.
//  With RdLatency=2, each x_rvalid_o arrives 2 cycles after its grant.
//  lu write idx 0x3C, way 0x04, data 0xABCDE -> sram_we_o=1, sram_way_o=0x04 same cycle.
//   No lu_rvalid_o follows the write.
//  rst_ni low one cycle after a read grant -> no rvalid afterwards; INIT_START re-entered.
//  STATS_EN: fl blocked 5 cycles by lu -> stall_cnt_o=5.
//   Without the macro stall_cnt_o stays 0.

Source files
------------

// File: rtl/axi_llc_tag_sram_sched.sv
// axi_llc_tag_sram_sched
// Owns the tag SRAM port of one LLC slice. After reset it starts the tag
// pattern generator and forwards the generator's SRAM traffic to all ways.
// Once the generator reports end of computation, it arbitrates between the
// lookup (lu) and flush (fl) requesters round-robin. Read completions are
// routed back to the issuing requester after RdLatency cycles.
// Optional feature: define AXI_LLC_TAG_SCHED_STATS_EN to build the
// saturating stall counter. Otherwise stall_cnt_o is tied to zero.
module axi_llc_tag_sram_sched #(
    parameter int SetAssociativity = 8,
    parameter int IndexLength      = 8,
    parameter int PatternWidth     = 20,
    parameter int RdLatency        = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    output logic                        init_done_o,
    output logic                        gen_valid_o,
    input  logic                        gen_ready_i,
    input  logic                        gen_req_i,
    input  logic                        gen_we_i,
    input  logic [IndexLength-1:0]      gen_index_i,
    input  logic [PatternWidth-1:0]     gen_pattern_i,
    input  logic                        gen_eoc_i,
    input  logic                        lu_valid_i,
    output logic                        lu_ready_o,
    input  logic                        lu_we_i,
    input  logic [SetAssociativity-1:0] lu_way_i,
    input  logic [IndexLength-1:0]      lu_index_i,
    input  logic [PatternWidth-1:0]     lu_wdata_i,
    output logic                        lu_rvalid_o,
    input  logic                        fl_valid_i,
    output logic                        fl_ready_o,
    input  logic                        fl_we_i,
    input  logic [SetAssociativity-1:0] fl_way_i,
    input  logic [IndexLength-1:0]      fl_index_i,
    input  logic [PatternWidth-1:0]     fl_wdata_i,
    output logic                        fl_rvalid_o,
    output logic                        sram_req_o,
    output logic                        sram_we_o,
    output logic [SetAssociativity-1:0] sram_way_o,
    output logic [IndexLength-1:0]      sram_index_o,
    output logic [PatternWidth-1:0]     sram_wdata_o,
    output logic [31:0]                 stall_cnt_o
);

    typedef enum logic [1:0] {
        INIT_START = 2'd0,
        INIT_RUN   = 2'd1,
        OPERATE    = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Round-robin pointer: 0 favours lookup, 1 favours flush.
    logic rr_q, rr_d;
    logic init_done_q;
    logic gen_start;
    logic grant_lu, grant_fl;
    logic push_rd;

    // Read-response pipeline: valid bits are control (reset), the
    // requester id travels alongside as data (no reset needed).
    logic [RdLatency-1:0] rd_vld_q;
    logic [RdLatency-1:0] rd_fl_q;

    // State, round-robin pointer and sticky init-done flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT_START;
            rr_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (state_q == INIT_RUN && gen_eoc_i) begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Next state, arbitration and SRAM port multiplexing.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gen_start    = 1'b0;
        grant_lu     = 1'b0;
        grant_fl     = 1'b0;
        lu_ready_o   = 1'b0;
        fl_ready_o   = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_way_o   = '0;
        sram_index_o = '0;
        sram_wdata_o = '0;
        case (state_q)
            INIT_START: begin
                gen_start = 1'b1;
                if (gen_ready_i) begin
                    state_d = INIT_RUN;
                end
            end
            INIT_RUN: begin
                // Initialisation writes every way of the addressed set.
                if (gen_req_i) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = gen_we_i;
                    sram_way_o   = '1;
                    sram_index_o = gen_index_i;
                    sram_wdata_o = gen_pattern_i;
                end
                if (gen_eoc_i) begin
                    state_d = OPERATE;
                end
            end
            OPERATE: begin
                grant_lu = lu_valid_i && (!fl_valid_i || !rr_q);
                grant_fl = fl_valid_i && (!lu_valid_i || rr_q);
                // On contention the loser gets priority next time.
                if (lu_valid_i && fl_valid_i) begin
                    rr_d = grant_lu;
                end
                lu_ready_o = grant_lu;
                fl_ready_o = grant_fl;
                if (grant_lu) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = lu_we_i;
                    sram_way_o   = lu_way_i;
                    sram_index_o = lu_index_i;
                    sram_wdata_o = lu_wdata_i;
                end else if (grant_fl) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = fl_we_i;
                    sram_way_o   = fl_way_i;
                    sram_index_o = fl_index_i;
                    sram_wdata_o = fl_wdata_i;
                end
            end
            default: begin
                state_d = INIT_START;
            end
        endcase
    end

    // Keep the generator start strobe low while reset is asserted.
    assign gen_valid_o = gen_start & rst_ni;
    assign init_done_o = init_done_q;
    assign push_rd     = (grant_lu | grant_fl) & ~sram_we_o;

    // Shift read-completion valid bits; reset drops reads in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q[0] <= push_rd;
            for (int i = 1; i < RdLatency; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
            end
        end
    end

    // Shift the requester id of each read alongside its valid bit.
    always_ff @(posedge clk_i) begin
        rd_fl_q[0] <= grant_fl;
        for (int i = 1; i < RdLatency; i++) begin
            rd_fl_q[i] <= rd_fl_q[i-1];
        end
    end

    assign lu_rvalid_o = rd_vld_q[RdLatency-1] & ~rd_fl_q[RdLatency-1];
    assign fl_rvalid_o = rd_vld_q[RdLatency-1] &  rd_fl_q[RdLatency-1];

`ifdef AXI_LLC_TAG_SCHED_STATS_EN
    logic [31:0] stall_cnt_q;
    logic        stall;

    // A stall is any operating cycle with a requester waiting for a grant.
    always_comb begin
        stall = (state_q == OPERATE) &&
                ((lu_valid_i && !lu_ready_o) || (fl_valid_i && !fl_ready_o));
    end

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_llc_tag_sram_sched.sv
// Directed testbench for axi_llc_tag_sram_sched (RdLatency = 2).
module tb_axi_llc_tag_sram_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        init_done_o, gen_valid_o, gen_ready_i, gen_req_i, gen_we_i;
    logic [7:0]  gen_index_i;
    logic [19:0] gen_pattern_i;
    logic        gen_eoc_i;
    logic        lu_valid_i, lu_ready_o, lu_we_i, lu_rvalid_o;
    logic [7:0]  lu_way_i, lu_index_i;
    logic [19:0] lu_wdata_i;
    logic        fl_valid_i, fl_ready_o, fl_we_i, fl_rvalid_o;
    logic [7:0]  fl_way_i, fl_index_i;
    logic [19:0] fl_wdata_i;
    logic        sram_req_o, sram_we_o;
    logic [7:0]  sram_way_o, sram_index_o;
    logic [19:0] sram_wdata_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    axi_llc_tag_sram_sched #(
        .SetAssociativity(8), .IndexLength(8), .PatternWidth(20), .RdLatency(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .init_done_o(init_done_o),
        .gen_valid_o(gen_valid_o), .gen_ready_i(gen_ready_i), .gen_req_i(gen_req_i),
        .gen_we_i(gen_we_i), .gen_index_i(gen_index_i), .gen_pattern_i(gen_pattern_i),
        .gen_eoc_i(gen_eoc_i),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_we_i(lu_we_i),
        .lu_way_i(lu_way_i), .lu_index_i(lu_index_i), .lu_wdata_i(lu_wdata_i),
        .lu_rvalid_o(lu_rvalid_o),
        .fl_valid_i(fl_valid_i), .fl_ready_o(fl_ready_o), .fl_we_i(fl_we_i),
        .fl_way_i(fl_way_i), .fl_index_i(fl_index_i), .fl_wdata_i(fl_wdata_i),
        .fl_rvalid_o(fl_rvalid_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_way_o(sram_way_o),
        .sram_index_o(sram_index_o), .sram_wdata_o(sram_wdata_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef AXI_LLC_TAG_SCHED_STATS_EN
        chk(tag, 64'(stall_cnt_o), 64'(exp_stall));
`else
        chk(tag, 64'(stall_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        rst_ni = 1'b0;
        gen_ready_i = 1'b1; gen_req_i = 1'b0; gen_we_i = 1'b0;
        gen_index_i = '0; gen_pattern_i = '0; gen_eoc_i = 1'b0;
        lu_valid_i = 1'b0; lu_we_i = 1'b0; lu_way_i = '0; lu_index_i = '0; lu_wdata_i = '0;
        fl_valid_i = 1'b0; fl_we_i = 1'b0; fl_way_i = '0; fl_index_i = '0; fl_wdata_i = '0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_gen_valid", 64'(gen_valid_o), 64'd0);
        chk("rst_init_done", 64'(init_done_o), 64'd0);
        chk("rst_sram_req", 64'(sram_req_o), 64'd0);
        chk("rst_sram_way", 64'(sram_way_o), 64'd0);
        chk("rst_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'd0);
        chk("rst_stall", 64'(stall_cnt_o), 64'd0);

        // Release reset: generator start strobe for exactly one cycle
        cyc(); rst_ni = 1'b1; #1;
        chk("start_gen_valid", 64'(gen_valid_o), 64'd1);

        // INIT_RUN: generator traffic to all ways; lookup blocked
        cyc();
        gen_req_i = 1'b1; gen_we_i = 1'b1; gen_index_i = 8'h12; gen_pattern_i = 20'h5A5A5;
        lu_valid_i = 1'b1; lu_we_i = 1'b0; lu_way_i = 8'h01; lu_index_i = 8'h10;
        #1;
        chk("run_gen_valid", 64'(gen_valid_o), 64'd0);
        chk("run_sram_req", 64'(sram_req_o), 64'd1);
        chk("run_sram_way", 64'(sram_way_o), 64'hFF);
        chk("run_sram_we", 64'(sram_we_o), 64'd1);
        chk("run_sram_index", 64'(sram_index_o), 64'h12);
        chk("run_sram_wdata", 64'(sram_wdata_o), 64'h5A5A5);
        chk("run_lu_ready", 64'(lu_ready_o), 64'd0);

        // EOC cycle N: still initialising
        cyc(); gen_req_i = 1'b0; gen_eoc_i = 1'b1; #1;
        chk("eoc_init_done", 64'(init_done_o), 64'd0);
        chk("eoc_lu_ready", 64'(lu_ready_o), 64'd0);
        chk("eoc_sram_req", 64'(sram_req_o), 64'd0);

        // N+1: operating; single lookup read granted, generator ignored
        cyc(); gen_eoc_i = 1'b0; gen_req_i = 1'b1; #1;
        chk("op_init_done", 64'(init_done_o), 64'd1);
        chk("op_lu_ready", 64'(lu_ready_o), 64'd1);
        chk("op_sram_req", 64'(sram_req_o), 64'd1);
        chk("op_sram_we", 64'(sram_we_o), 64'd0);
        chk("op_sram_way", 64'(sram_way_o), 64'h01);
        chk("op_sram_index", 64'(sram_index_o), 64'h10);

        cyc(); lu_valid_i = 1'b0; gen_req_i = 1'b0; #1;
        chk("rd1_lat1_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        chk("idle_sram_req", 64'(sram_req_o), 64'd0);
        chk("idle_sram_way", 64'(sram_way_o), 64'd0);
        chk("idle_init_done", 64'(init_done_o), 64'd1);
        cyc();
        chk("rd1_lat2_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b10);
        cyc();
        chk("rd1_lat3_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);

        // Both requesters read for 4 cycles: grants alternate lu,fl,lu,fl
        cyc();
        lu_valid_i = 1'b1; lu_we_i = 1'b0; lu_way_i = 8'h02; lu_index_i = 8'h20;
        fl_valid_i = 1'b1; fl_we_i = 1'b0; fl_way_i = 8'h80; fl_index_i = 8'h30;
        #1;
        chk("rr1_ready", 64'({lu_ready_o, fl_ready_o}), 64'b10);
        chk("rr1_index", 64'(sram_index_o), 64'h20);
        chk("rr1_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        exp_stall++;
        cyc();
        chk("rr2_ready", 64'({lu_ready_o, fl_ready_o}), 64'b01);
        chk("rr2_index", 64'(sram_index_o), 64'h30);
        chk("rr2_way", 64'(sram_way_o), 64'h80);
        chk("rr2_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        exp_stall++;
        cyc();
        chk("rr3_ready", 64'({lu_ready_o, fl_ready_o}), 64'b10);
        chk("rr3_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b10);
        exp_stall++;
        cyc();
        chk("rr4_ready", 64'({lu_ready_o, fl_ready_o}), 64'b01);
        chk("rr4_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b01);
        exp_stall++;
        cyc(); lu_valid_i = 1'b0; fl_valid_i = 1'b0; #1;
        chk("rr5_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b10);
        cyc();
        chk("rr6_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b01);
        cyc();
        chk("rr7_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        chk_stats("stall_after_rr");

        // Lookup write: no completion follows
        lu_valid_i = 1'b1; lu_we_i = 1'b1; lu_way_i = 8'h04;
        lu_index_i = 8'h3C; lu_wdata_i = 20'hABCDE;
        #1;
        chk("wr_ready", 64'(lu_ready_o), 64'd1);
        chk("wr_sram_req", 64'(sram_req_o), 64'd1);
        chk("wr_sram_we", 64'(sram_we_o), 64'd1);
        chk("wr_sram_way", 64'(sram_way_o), 64'h04);
        chk("wr_sram_index", 64'(sram_index_o), 64'h3C);
        chk("wr_sram_wdata", 64'(sram_wdata_o), 64'hABCDE);
        cyc(); lu_valid_i = 1'b0; lu_we_i = 1'b0; #1;
        chk("wr_lat1_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        cyc();
        chk("wr_lat2_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        cyc();
        chk("wr_lat3_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        chk_stats("stall_after_wr");

        // Read grant, then reset one cycle later: the completion is dropped
        lu_valid_i = 1'b1; lu_index_i = 8'h55; #1;
        chk("rstrd_ready", 64'(lu_ready_o), 64'd1);
        cyc(); lu_valid_i = 1'b0; rst_ni = 1'b0; gen_ready_i = 1'b0; #1;
        chk("rstrd_rvalid_a", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        chk("rstrd_init_done", 64'(init_done_o), 64'd0);
        chk("rstrd_gen_valid", 64'(gen_valid_o), 64'd0);
        chk("rstrd_stall", 64'(stall_cnt_o), 64'd0);
        cyc();
        chk("rstrd_rvalid_b", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        rst_ni = 1'b1; #1;
        chk("restart_gen_valid", 64'(gen_valid_o), 64'd1);
        cyc();
        chk("restart_hold_gen_valid", 64'(gen_valid_o), 64'd1);
        chk("restart_rvalid", 64'({lu_rvalid_o, fl_rvalid_o}), 64'b00);
        gen_ready_i = 1'b1;
        cyc(); lu_valid_i = 1'b1; #1;
        chk("restart_run_gen_valid", 64'(gen_valid_o), 64'd0);
        chk("restart_run_lu_ready", 64'(lu_ready_o), 64'd0);
        chk("restart_run_init_done", 64'(init_done_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
